// File: rtl/imem_responder_if.sv
// imem_responder_if: fetch, response and load signals of the instruction-memory
// responder, grouped into one bundle with a core-side (master) and a
// responder-side (slave) view.
//
// Handshake semantics (both channels): a transfer happens on a rising clock
// edge where valid and ready are both high. Once rsp_valid is raised, the
// responder holds it and every rsp_* field stable until that transfer edge.
// The core keeps req_valid and req_addr stable until the request transfers.
// The ready signals never depend on the matching valid in the same cycle.
interface imem_responder_if #(
   parameter int ADDR_W = 16,
   parameter int DEPTH  = 1024
);
   localparam int AW = $clog2(DEPTH);

   logic              req_valid;
   logic              req_ready;
   logic [ADDR_W-1:0] req_addr;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [31:0]       rsp_instr;
   logic [ADDR_W-1:0] rsp_addr;
   logic              rsp_eop;
   logic              rsp_fault;
   logic              ld_en;
   logic [AW-1:0]     ld_addr;
   logic [31:0]       ld_data;
   logic              ld_ready;
   logic [AW:0]       prog_len;

   modport master (
      output req_valid, req_addr, rsp_ready, ld_en, ld_addr, ld_data,
      input  req_ready, rsp_valid, rsp_instr, rsp_addr, rsp_eop, rsp_fault,
             ld_ready, prog_len
   );

   modport slave (
      input  req_valid, req_addr, rsp_ready, ld_en, ld_addr, ld_data,
      output req_ready, rsp_valid, rsp_instr, rsp_addr, rsp_eop, rsp_fault,
             ld_ready, prog_len
   );
endinterface

// File: rtl/imem_responder.sv
// imem_responder: instruction-memory responder for the rv32i fetch port.
// Accepts a byte address, waits WAIT_CYCLES cycles plus the array read cycle,
// and returns the 32-bit word over a valid/ready handshake. A side load port
// fills the array and tracks the loaded program length (prog_len); fetches at
// or past prog_len return a NOP flagged with rsp_eop.
// Compile-time option: define IMEM_BOUNDS_CHECK_EN to fault word indices
// >= DEPTH; without it the word index wraps modulo DEPTH.
// Assumes ADDR_W >= $clog2(DEPTH) + 2 so the full word index fits the address.
module imem_responder #(
   parameter int ADDR_W      = 16,
   parameter int DEPTH       = 1024,
   parameter int WAIT_CYCLES = 2
) (
   input  logic            clk,
   input  logic            rst,
   imem_responder_if.slave bus,
   output logic [1:0]      o_dbg_state
);
   localparam int          AW  = $clog2(DEPTH);
   localparam int          CW  = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [CW-1:0]     r_cnt;
   logic [CW-1:0]     w_cnt_nxt;
   logic [ADDR_W-1:0] r_req_addr;
   logic [31:0]       r_rsp_instr;
   logic              r_rsp_eop;
   logic              r_rsp_fault;
   logic [AW:0]       r_prog_len;
   logic [31:0]       r_mem [DEPTH];

   logic              w_accept;
   logic              w_load;
   logic              w_fire;
   logic [AW-1:0]     w_mem_idx;
   logic              w_misal;
   logic              w_oob;
   logic              w_fault;
   logic              w_eop;
   logic [31:0]       w_instr;
   logic [AW:0]       w_ld_len;

   // Response decode from the captured request address. The low word-index
   // bits select the array entry; in the wrapping build they are also the
   // index compared against prog_len, so a wrapped fetch behaves like a
   // fetch of the word it aliases.
   assign w_mem_idx = r_req_addr[AW+1:2];
   assign w_misal   = |r_req_addr[1:0];

`ifdef IMEM_BOUNDS_CHECK_EN
   generate
      if (ADDR_W > AW + 2) begin : g_oob
         assign w_oob = |r_req_addr[ADDR_W-1:AW+2];
      end else begin : g_no_oob
         assign w_oob = 1'b0;
      end
   endgenerate
`else
   assign w_oob = 1'b0;
`endif

   assign w_fault = w_misal | w_oob;
   assign w_eop   = !w_fault && ({1'b0, w_mem_idx} >= r_prog_len);
   assign w_instr = (w_fault || w_eop) ? NOP : r_mem[w_mem_idx];

   // Length a load would imply; ld_addr <= DEPTH-1 so this saturates at DEPTH.
   assign w_ld_len = {1'b0, bus.ld_addr} + {{AW{1'b0}}, 1'b1};

   // Next-state logic: loads take priority over fetches in IDLE; the wait
   // counter holds the number of cycles left before the array read edge.
   // With WAIT_CYCLES=0 the counter starts at zero, so the read happens on
   // the first edge after accept and the response follows immediately.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_accept    = 1'b0;
      w_load      = 1'b0;
      w_fire      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.ld_en) begin
               w_load = 1'b1;
            end else if (bus.req_valid) begin
               w_accept    = 1'b1;
               w_cnt_nxt   = CW'(WAIT_CYCLES);
               w_state_nxt = S_WAIT;
            end
         end
         S_WAIT: begin
            if (r_cnt == '0) begin
               w_fire      = 1'b1;
               w_state_nxt = S_RESP;
            end else begin
               w_cnt_nxt = r_cnt - CW'(1);
            end
         end
         S_RESP: begin
            if (bus.rsp_ready) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // State, counter, captured address, response fields and program length.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_req_addr  <= '0;
         r_rsp_instr <= '0;
         r_rsp_eop   <= 1'b0;
         r_rsp_fault <= 1'b0;
         r_prog_len  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         if (w_accept) begin
            r_req_addr <= bus.req_addr;
         end
         if (w_fire) begin
            r_rsp_instr <= w_instr;
            r_rsp_eop   <= w_eop;
            r_rsp_fault <= w_fault;
         end
         if (w_load && (w_ld_len > r_prog_len)) begin
            r_prog_len <= w_ld_len;
         end
      end
   end

   // Instruction array write port; contents survive reset.
   always_ff @(posedge clk) begin
      if (w_load) begin
         r_mem[bus.ld_addr] <= bus.ld_data;
      end
   end

   assign bus.req_ready = (r_state == S_IDLE) && !bus.ld_en;
   assign bus.ld_ready  = (r_state == S_IDLE);
   assign bus.rsp_valid = (r_state == S_RESP);
   assign bus.rsp_instr = r_rsp_instr;
   assign bus.rsp_addr  = r_req_addr;
   assign bus.rsp_eop   = r_rsp_eop;
   assign bus.rsp_fault = r_rsp_fault;
   assign bus.prog_len  = r_prog_len;
   assign o_dbg_state   = r_state;
endmodule

// File: tb/tb_imem_responder.sv
// tb_imem_responder: randomized and directed checks of imem_responder against
// a word-level model (array + program length) kept in the bench.
// Honours IMEM_BOUNDS_CHECK_EN for the bounds/wrap scenario.
`timescale 1ns/1ps
module tb_imem_responder;
   localparam int          ADDR_W      = 16;
   localparam int          DEPTH       = 1024;
   localparam int          WAIT_CYCLES = 2;
   localparam int          SDEPTH      = 16;
   localparam int          EXP_LAT     = WAIT_CYCLES + 1;
   localparam logic [31:0] NOP         = 32'h0000_0013;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] dbg_state;
   logic [1:0] sdbg_state;
   int         checks   = 0;
   int         failures = 0;

   logic [31:0] prog [4] = '{32'h00500093, 32'h00a00113, 32'h002081b3, 32'h00302023};

   // behavioural model of the main instance
   logic [31:0] m_mem [DEPTH];
   bit          m_written [DEPTH];
   int          m_len = 0;
   logic [31:0] exp_q [$];

   imem_responder_if #(.ADDR_W(ADDR_W), .DEPTH(DEPTH))  bus ();
   imem_responder_if #(.ADDR_W(ADDR_W), .DEPTH(SDEPTH)) sbus ();

   imem_responder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .WAIT_CYCLES(WAIT_CYCLES)) dut (
      .clk(clk), .rst(rst), .bus(bus), .o_dbg_state(dbg_state));

   imem_responder #(.ADDR_W(ADDR_W), .DEPTH(SDEPTH), .WAIT_CYCLES(WAIT_CYCLES)) sdut (
      .clk(clk), .rst(rst), .bus(sbus), .o_dbg_state(sdbg_state));

   // clock / reset block
   always #5 clk = ~clk;

   initial begin
      bus.req_valid  = 0; bus.req_addr  = '0; bus.rsp_ready  = 0;
      bus.ld_en      = 0; bus.ld_addr   = '0; bus.ld_data    = '0;
      sbus.req_valid = 0; sbus.req_addr = '0; sbus.rsp_ready = 0;
      sbus.ld_en     = 0; sbus.ld_addr  = '0; sbus.ld_data   = '0;
   end

   // model: response expected for a byte address under the spec's rules
   function automatic void model_fetch(input int addr, output logic [31:0] instr,
                                       output bit eop, output bit fault, output bit known);
      int idx;
      idx   = addr / 4;
      known = 1;
      eop   = 0;
      fault = 0;
      instr = NOP;
      if (addr % 4 != 0) begin
         fault = 1;
`ifdef IMEM_BOUNDS_CHECK_EN
      end else if (idx >= DEPTH) begin
         fault = 1;
`endif
      end else begin
         idx = idx % DEPTH;
         if (idx >= m_len) eop = 1;
         else begin
            instr = m_mem[idx];
            known = m_written[idx];
         end
      end
   endfunction

   // driver: one load on the main instance, model updated alongside
   task automatic drv_load(input int idx, input logic [31:0] data);
      bus.ld_en   = 1;
      bus.ld_addr = idx[9:0];
      bus.ld_data = data;
      @(posedge clk); #1;
      bus.ld_en = 0;
      m_mem[idx]     = data;
      m_written[idx] = 1;
      if (idx + 1 > m_len) m_len = idx + 1;
   endtask

   // driver: one fetch on the main instance (called from IDLE), holding
   // rsp_ready low for 'hold' cycles once the response is valid
   task automatic drv_fetch(input int addr, input int hold,
                            output logic [31:0] instr, output logic [15:0] raddr,
                            output logic eop, output logic fault, output int lat,
                            output bit stable, output bit consumed);
      bus.req_valid = 1;
      bus.req_addr  = addr[15:0];
      bus.rsp_ready = (hold == 0);
      @(posedge clk); #1;
      bus.req_valid = 0;
      lat = 0;
      while (!bus.rsp_valid && lat < 50) begin
         @(posedge clk); #1;
         lat++;
      end
      instr  = bus.rsp_instr;
      raddr  = bus.rsp_addr;
      eop    = bus.rsp_eop;
      fault  = bus.rsp_fault;
      stable = 1;
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         if (!bus.rsp_valid || bus.req_ready || bus.rsp_instr !== instr ||
             bus.rsp_addr !== raddr || bus.rsp_eop !== eop || bus.rsp_fault !== fault)
            stable = 0;
      end
      bus.rsp_ready = 1;
      @(posedge clk); #1;
      consumed = !bus.rsp_valid;
   endtask

   task automatic test_reset;
      repeat (3) @(posedge clk);
      #1 rst = 0;
      #1;
      checks++; if (bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", bus.rsp_valid); end
      checks++; if (bus.rsp_instr !== 32'h0) begin failures++; $display("FAIL reset_rsp_instr got=%h exp=0", bus.rsp_instr); end
      checks++; if (bus.rsp_addr !== 16'h0) begin failures++; $display("FAIL reset_rsp_addr got=%h exp=0", bus.rsp_addr); end
      checks++; if (bus.rsp_eop !== 1'b0 || bus.rsp_fault !== 1'b0) begin failures++; $display("FAIL reset_flags got=%b%b exp=00", bus.rsp_eop, bus.rsp_fault); end
      checks++; if (bus.prog_len !== 11'd0) begin failures++; $display("FAIL reset_prog_len got=%0d exp=0", bus.prog_len); end
      checks++; if (bus.req_ready !== 1'b1 || bus.ld_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b%b exp=11", bus.req_ready, bus.ld_ready); end
      checks++; if (dbg_state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
   endtask

   task automatic test_program;
      logic [31:0] instr; logic [15:0] raddr; logic eop, fault; int lat; bit st, cons;
      for (int i = 0; i < 4; i++) drv_load(i, prog[i]);
      checks++; if (bus.prog_len !== 11'd4) begin failures++; $display("FAIL prog_len got=%0d exp=4", bus.prog_len); end
      for (int i = 0; i < 4; i++) begin
         drv_fetch(i * 4, 0, instr, raddr, eop, fault, lat, st, cons);
         checks++; if (instr !== prog[i]) begin failures++; $display("FAIL prog_instr[%0d] got=%h exp=%h", i, instr, prog[i]); end
         checks++; if (raddr !== 16'(i * 4)) begin failures++; $display("FAIL prog_addr[%0d] got=%h exp=%h", i, raddr, 16'(i * 4)); end
         checks++; if (eop !== 1'b0 || fault !== 1'b0) begin failures++; $display("FAIL prog_flags[%0d] got=%b%b exp=00", i, eop, fault); end
         checks++; if (lat != EXP_LAT) begin failures++; $display("FAIL prog_latency[%0d] got=%0d exp=%0d", i, lat, EXP_LAT); end
         checks++; if (!cons) begin failures++; $display("FAIL prog_consume[%0d] got=0 exp=1", i); end
      end
   endtask

   task automatic test_eop;
      logic [31:0] instr; logic [15:0] raddr; logic eop, fault; int lat; bit st, cons;
      drv_fetch(16, 0, instr, raddr, eop, fault, lat, st, cons);
      checks++; if (instr !== NOP) begin failures++; $display("FAIL eop_instr got=%h exp=%h", instr, NOP); end
      checks++; if (eop !== 1'b1) begin failures++; $display("FAIL eop_flag got=%b exp=1", eop); end
      checks++; if (fault !== 1'b0) begin failures++; $display("FAIL eop_fault got=%b exp=0", fault); end
   endtask

   task automatic test_misaligned;
      logic [31:0] instr; logic [15:0] raddr; logic eop, fault; int lat; bit st, cons;
      drv_fetch(6, 0, instr, raddr, eop, fault, lat, st, cons);
      checks++; if (fault !== 1'b1) begin failures++; $display("FAIL misal_fault got=%b exp=1", fault); end
      checks++; if (instr !== NOP) begin failures++; $display("FAIL misal_instr got=%h exp=%h", instr, NOP); end
      checks++; if (eop !== 1'b0) begin failures++; $display("FAIL misal_eop got=%b exp=0", eop); end
      checks++; if (raddr !== 16'd6) begin failures++; $display("FAIL misal_addr got=%h exp=6", raddr); end
   endtask

   task automatic test_backpressure;
      logic [31:0] instr; logic [15:0] raddr; logic eop, fault; int lat; bit st, cons;
      drv_fetch(8, 5, instr, raddr, eop, fault, lat, st, cons);
      checks++; if (!st) begin failures++; $display("FAIL bp_stable got=0 exp=1"); end
      checks++; if (!cons) begin failures++; $display("FAIL bp_consume got=0 exp=1"); end
      checks++; if (instr !== prog[2]) begin failures++; $display("FAIL bp_instr got=%h exp=%h", instr, prog[2]); end
   endtask

   task automatic test_load_arb;
      int lat;
      bus.ld_en = 1; bus.ld_addr = 10'd5; bus.ld_data = 32'h00100293;
      bus.req_valid = 1; bus.req_addr = 16'd20; bus.rsp_ready = 1;
      #1;
      checks++; if (bus.req_ready !== 1'b0 || bus.ld_ready !== 1'b1) begin failures++; $display("FAIL arb_ready got=%b%b exp=01", bus.req_ready, bus.ld_ready); end
      @(posedge clk); #1;
      bus.ld_en = 0;
      m_mem[5] = 32'h00100293; m_written[5] = 1; m_len = 6;
      #1;
      checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL arb_req_ready_after_load got=%b exp=1", bus.req_ready); end
      @(posedge clk); #1;
      bus.req_valid = 0;
      checks++; if (bus.req_ready !== 1'b0 || bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL arb_accept got=%b%b exp=00", bus.req_ready, bus.rsp_valid); end
      lat = 0;
      while (!bus.rsp_valid && lat < 50) begin @(posedge clk); #1; lat++; end
      checks++; if (lat != EXP_LAT) begin failures++; $display("FAIL arb_latency got=%0d exp=%0d", lat, EXP_LAT); end
      checks++; if (bus.rsp_instr !== 32'h00100293) begin failures++; $display("FAIL arb_instr got=%h exp=00100293", bus.rsp_instr); end
      checks++; if (bus.prog_len !== 11'd6) begin failures++; $display("FAIL arb_prog_len got=%0d exp=6", bus.prog_len); end
      @(posedge clk); #1;
   endtask

   task automatic test_random;
      logic [31:0] instr, e_instr; logic [15:0] raddr; logic eop, fault; int lat; bit st, cons;
      bit e_eop, e_fault, known; int idx, addr, hold;
      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            idx = $urandom_range(0, 31);
            drv_load(idx, $urandom);
            checks++; if (bus.prog_len !== 11'(m_len)) begin failures++; $display("FAIL rnd_prog_len[%0d] got=%0d exp=%0d", i, bus.prog_len, m_len); end
         end else begin
            idx  = $urandom_range(0, 40);
            addr = idx * 4 + (($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0);
            hold = $urandom_range(0, 2);
            model_fetch(addr, e_instr, e_eop, e_fault, known);
            exp_q.push_back(e_instr);
            drv_fetch(addr, hold, instr, raddr, eop, fault, lat, st, cons);
            e_instr = exp_q.pop_front();
            if (known) begin
               checks++; if (instr !== e_instr) begin failures++; $display("FAIL rnd_instr[%0d] addr=%0d got=%h exp=%h", i, addr, instr, e_instr); end
            end
            checks++; if (eop !== e_eop || fault !== e_fault) begin failures++; $display("FAIL rnd_flags[%0d] addr=%0d got=%b%b exp=%b%b", i, addr, eop, fault, e_eop, e_fault); end
            checks++; if (raddr !== 16'(addr)) begin failures++; $display("FAIL rnd_addr[%0d] got=%h exp=%h", i, raddr, 16'(addr)); end
            checks++; if (lat != EXP_LAT || !st || !cons) begin failures++; $display("FAIL rnd_timing[%0d] lat=%0d stable=%0d consumed=%0d exp=%0d/1/1", i, lat, st, cons, EXP_LAT); end
         end
      end
   endtask

   task automatic test_reset_wait;
      bit seen;
      bus.req_valid = 1; bus.req_addr = 16'd8; bus.rsp_ready = 1;
      @(posedge clk); #1;
      bus.req_valid = 0;
      @(posedge clk); #1;
      rst = 1;
      #1;
      checks++; if (bus.rsp_valid !== 1'b0 || bus.rsp_instr !== 32'h0 || bus.rsp_addr !== 16'h0 ||
                    bus.rsp_eop !== 1'b0 || bus.rsp_fault !== 1'b0) begin
         failures++; $display("FAIL rstw_outputs got=%b/%h/%h/%b/%b exp=0/0/0/0/0", bus.rsp_valid, bus.rsp_instr, bus.rsp_addr, bus.rsp_eop, bus.rsp_fault);
      end
      checks++; if (bus.prog_len !== 11'd0) begin failures++; $display("FAIL rstw_prog_len got=%0d exp=0", bus.prog_len); end
      checks++; if (dbg_state !== 2'd0) begin failures++; $display("FAIL rstw_state got=%0d exp=0", dbg_state); end
      @(posedge clk); #1;
      rst = 0;
      m_len = 0;
      seen = 0;
      repeat (8) begin @(posedge clk); #1; if (bus.rsp_valid) seen = 1; end
      checks++; if (seen) begin failures++; $display("FAIL rstw_no_rsp got=1 exp=0"); end
   endtask

   task automatic test_bounds;
      int lat;
      logic [31:0] e_instr; logic e_fault;
`ifdef IMEM_BOUNDS_CHECK_EN
      e_instr = NOP; e_fault = 1'b1;
`else
      e_instr = 32'hcafe0537; e_fault = 1'b0;
`endif
      sbus.ld_en = 1; sbus.ld_addr = 4'd0; sbus.ld_data = 32'hcafe0537;
      @(posedge clk); #1;
      sbus.ld_en = 0;
      checks++; if (sbus.prog_len !== 5'd1) begin failures++; $display("FAIL bnd_prog_len got=%0d exp=1", sbus.prog_len); end
      sbus.req_valid = 1; sbus.req_addr = 16'd64; sbus.rsp_ready = 1;
      @(posedge clk); #1;
      sbus.req_valid = 0;
      lat = 0;
      while (!sbus.rsp_valid && lat < 50) begin @(posedge clk); #1; lat++; end
      checks++; if (lat != EXP_LAT) begin failures++; $display("FAIL bnd_latency got=%0d exp=%0d", lat, EXP_LAT); end
      checks++; if (sbus.rsp_instr !== e_instr) begin failures++; $display("FAIL bnd_instr got=%h exp=%h", sbus.rsp_instr, e_instr); end
      checks++; if (sbus.rsp_fault !== e_fault || sbus.rsp_eop !== 1'b0) begin failures++; $display("FAIL bnd_flags got=%b%b exp=%b0", sbus.rsp_fault, sbus.rsp_eop, e_fault); end
      @(posedge clk); #1;
      checks++; if (sbus.rsp_valid !== 1'b0) begin failures++; $display("FAIL bnd_consume got=1 exp=0"); end
   endtask

   initial begin
      test_reset;
      test_program;
      test_eop;
      test_misaligned;
      test_backpressure;
      test_load_arb;
      test_random;
      test_reset_wait;
      test_bounds;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
